// File: rtl/wb_stage_pkg.sv
// Shared constants, FSM state type and load-formatting helper for the writeback stage.
package wb_stage_pkg;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_RSV = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_RSP = 1'b1
    } state_t;

    // Halfword selection uses offset[1] only; unknown funct3 encodings fall back to a full word.
    function automatic logic [31:0] load_format(input logic [2:0]  funct3,
                                                input logic [1:0]  offset,
                                                input logic [31:0] word);
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        byte_sel = word[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_LB:   return {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  return {24'h000000, byte_sel};
            F3_LH:   return {{16{half_sel[15]}}, half_sel};
            F3_LHU:  return {16'h0000, half_sel};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load data extraction and sign/zero extension.
module load_align
    import wb_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    output logic [31:0] data
);

    assign data = load_format(funct3, offset, word);

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: retires ALU/link results in one cycle, holds loads until the memory response arrives.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  wb_en_in,
    input  logic [1:0]            wb_sel_in,
    input  logic [4:0]            rd_in,
    input  logic [2:0]            funct3_in,
    input  logic [DATA_WIDTH-1:0] alu_result_in,
    input  logic [DATA_WIDTH-1:0] pc_plus4_in,
    input  logic                  dmem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] dmem_rsp_data,
    output logic                  wb_en,
    output logic [4:0]            wb_rd,
    output logic [DATA_WIDTH-1:0] wb_data
);

    state_t      state;
    state_t      state_next;
    logic        accept;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic        ld_en;
    logic [1:0]  ld_offset;
    logic [31:0] aligned;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;

    load_align u_load_align (
        .funct3 (ld_funct3),
        .offset (ld_offset),
        .word   (dmem_rsp_data),
        .data   (aligned)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (accept && wb_sel_in == WB_MEM) state_next = WAIT_RSP;
            WAIT_RSP: if (dmem_rsp_valid) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // wb_en defaults low every cycle so it only pulses on a retirement; rd/data hold otherwise.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wb_en     <= 1'b0;
            wb_rd     <= 5'd0;
            wb_data   <= '0;
            ld_rd     <= 5'd0;
            ld_funct3 <= 3'd0;
            ld_en     <= 1'b0;
            ld_offset <= 2'd0;
        end else begin
            wb_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (wb_sel_in == WB_MEM) begin
                            ld_rd     <= rd_in;
                            ld_funct3 <= funct3_in;
                            ld_en     <= wb_en_in;
                            ld_offset <= alu_result_in[1:0];
                        end else begin
                            wb_en   <= wb_en_in && (rd_in != 5'd0) && (wb_sel_in != WB_RSV);
                            wb_rd   <= rd_in;
                            wb_data <= (wb_sel_in == WB_PC4) ? pc_plus4_in : alu_result_in;
                        end
                    end
                end
                WAIT_RSP: begin
                    if (dmem_rsp_valid) begin
                        wb_en   <= ld_en && (ld_rd != 5'd0);
                        wb_rd   <= ld_rd;
                        wb_data <= aligned;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: expected retirements are queued by the driver and popped by the monitor.
module tb_wb_stage;
    import wb_stage_pkg::*;

    typedef struct {
        logic        en;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        arst_n;
    logic        in_valid;
    logic        in_ready;
    logic        wb_en_in;
    logic [1:0]  wb_sel_in;
    logic [4:0]  rd_in;
    logic [2:0]  funct3_in;
    logic [31:0] alu_result_in;
    logic [31:0] pc_plus4_in;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rsp_data;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    exp_t        exp_q[$];
    logic [4:0]  last_rd;
    logic [31:0] last_data;
    int          errors;
    int          checks;

    wb_stage #(.DATA_WIDTH(32)) dut (
        .clk            (clk),
        .arst_n         (arst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .wb_en_in       (wb_en_in),
        .wb_sel_in      (wb_sel_in),
        .rd_in          (rd_in),
        .funct3_in      (funct3_in),
        .alu_result_in  (alu_result_in),
        .pc_plus4_in    (pc_plus4_in),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rsp_data  (dmem_rsp_data),
        .wb_en          (wb_en),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, expv, $time);
        end
    endtask

    // Each cycle either a queued retirement is due or outputs must be quiet and holding.
    always @(posedge clk) begin
        exp_t item;
        #1;
        if (exp_q.size() > 0) begin
            item = exp_q.pop_front();
            checkOutput("ret_en", {31'd0, wb_en}, {31'd0, item.en});
            checkOutput("ret_rd", {27'd0, wb_rd}, {27'd0, item.rd});
            checkOutput("ret_data", wb_data, item.data);
            last_rd   = item.rd;
            last_data = item.data;
        end else begin
            checkOutput("quiet_en", {31'd0, wb_en}, 32'd0);
            checkOutput("hold_rd", {27'd0, wb_rd}, {27'd0, last_rd});
            checkOutput("hold_data", wb_data, last_data);
        end
    end

    task automatic idleCycles(input int n, input logic rsp);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid       = 1'b0;
            dmem_rsp_valid = rsp;
            dmem_rsp_data  = 32'hA5A5_5A5A;
        end
    endtask

    task automatic applyStimulus(input logic [1:0] sel, input logic en, input logic [4:0] rd,
                                 input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc4,
                                 input int delay, input logic [31:0] rsp, input logic [31:0] exp_data);
        exp_t item;
        @(negedge clk);
        dmem_rsp_valid = 1'b0;
        in_valid       = 1'b1;
        wb_sel_in      = sel;
        wb_en_in       = en;
        rd_in          = rd;
        funct3_in      = f3;
        alu_result_in  = alu;
        pc_plus4_in    = pc4;
        checkOutput("ready_idle", {31'd0, in_ready}, 32'd1);
        item.en   = en && (rd != 5'd0) && (sel != WB_RSV);
        item.rd   = rd;
        item.data = exp_data;
        if (sel != WB_MEM) begin
            exp_q.push_back(item);
            @(posedge clk);
        end else begin
            @(posedge clk);
            for (int i = 0; i < delay; i++) begin
                @(negedge clk);
                rd_in         = ~rd;
                funct3_in     = ~f3;
                alu_result_in = ~alu;
                checkOutput("ready_wait", {31'd0, in_ready}, 32'd0);
            end
            @(negedge clk);
            rd_in          = ~rd;
            funct3_in      = ~f3;
            alu_result_in  = ~alu;
            dmem_rsp_valid = 1'b1;
            dmem_rsp_data  = rsp;
            checkOutput("ready_rsp", {31'd0, in_ready}, 32'd0);
            exp_q.push_back(item);
            @(posedge clk);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        last_rd = 5'd0;
        last_data = 32'd0;
        arst_n = 1'b0;
        in_valid = 1'b0;
        wb_en_in = 1'b0;
        wb_sel_in = WB_ALU;
        rd_in = 5'd0;
        funct3_in = 3'd0;
        alu_result_in = 32'd0;
        pc_plus4_in = 32'd0;
        dmem_rsp_valid = 1'b0;
        dmem_rsp_data = 32'd0;

        #2;
        checkOutput("rst_en", {31'd0, wb_en}, 32'd0);
        checkOutput("rst_rd", {27'd0, wb_rd}, 32'd0);
        checkOutput("rst_data", wb_data, 32'd0);
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        checkOutput("ready_after_por", {31'd0, in_ready}, 32'd1);

        applyStimulus(WB_ALU, 1'b1, 5'd5, 3'd0, 32'h1234_5678, 32'h0,  0, 32'h0,         32'h1234_5678);
        idleCycles(1, 1'b0);
        applyStimulus(WB_MEM, 1'b1, 5'd6, F3_LB,  32'h0000_1003, 32'h0, 0, 32'h80FF_0000, 32'hFFFF_FF80);
        applyStimulus(WB_MEM, 1'b1, 5'd6, F3_LBU, 32'h0000_1003, 32'h0, 0, 32'h80FF_0000, 32'h0000_0080);
        applyStimulus(WB_MEM, 1'b1, 5'd7, F3_LH,  32'h0000_2002, 32'h0, 1, 32'h8001_7FFF, 32'hFFFF_8001);
        applyStimulus(WB_MEM, 1'b1, 5'd7, F3_LHU, 32'h0000_2000, 32'h0, 0, 32'h8001_7FFF, 32'h0000_7FFF);
        applyStimulus(WB_MEM, 1'b1, 5'd8, F3_LH,  32'h0000_2003, 32'h0, 0, 32'h8001_7FFF, 32'hFFFF_8001);
        applyStimulus(WB_MEM, 1'b1, 5'd9, F3_LW,  32'h0000_3001, 32'h0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        applyStimulus(WB_MEM, 1'b1, 5'd9, 3'b011, 32'h0000_3002, 32'h0, 0, 32'h0123_4567, 32'h0123_4567);
        applyStimulus(WB_MEM, 1'b1, 5'd10, F3_LB, 32'h0000_4001, 32'h0, 0, 32'h0000_7F00, 32'h0000_007F);
        applyStimulus(WB_MEM, 1'b1, 5'd11, F3_LW, 32'h0000_5000, 32'h0, 4, 32'hCAFE_F00D, 32'hCAFE_F00D);
        applyStimulus(WB_ALU, 1'b1, 5'd12, 3'd0,  32'h0000_0055, 32'h0, 0, 32'h0,         32'h0000_0055);
        applyStimulus(WB_PC4, 1'b1, 5'd0, 3'd0,   32'hFFFF_0000, 32'h104, 0, 32'h0,       32'h0000_0104);
        applyStimulus(WB_PC4, 1'b1, 5'd1, 3'd0,   32'hFFFF_0000, 32'h104, 0, 32'h0,       32'h0000_0104);
        applyStimulus(WB_ALU, 1'b0, 5'd3, 3'd0,   32'h0000_0777, 32'h0, 0, 32'h0,         32'h0000_0777);
        applyStimulus(WB_RSV, 1'b1, 5'd4, 3'd0,   32'h0000_0099, 32'h0, 0, 32'h0,         32'h0000_0099);
        applyStimulus(WB_MEM, 1'b1, 5'd0, F3_LW,  32'h0000_6000, 32'h0, 2, 32'h1111_2222, 32'h1111_2222);
        applyStimulus(WB_MEM, 1'b0, 5'd13, F3_LW, 32'h0000_6000, 32'h0, 0, 32'h3333_4444, 32'h3333_4444);

        // Stray responses in IDLE must be invisible.
        idleCycles(3, 1'b1);
        idleCycles(1, 1'b0);
        applyStimulus(WB_ALU, 1'b1, 5'd14, 3'd0, 32'h0BAD_F00D, 32'h0, 0, 32'h0, 32'h0BAD_F00D);

        // Abandon a pending load via reset, then deliver its response late.
        @(negedge clk);
        in_valid  = 1'b1;
        wb_sel_in = WB_MEM;
        wb_en_in  = 1'b1;
        rd_in     = 5'd15;
        funct3_in = F3_LW;
        alu_result_in = 32'h0000_7000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("ready_pending", {31'd0, in_ready}, 32'd0);
        #2;
        arst_n    = 1'b0;
        last_rd   = 5'd0;
        last_data = 32'd0;
        #1;
        checkOutput("arst_en", {31'd0, wb_en}, 32'd0);
        checkOutput("arst_rd", {27'd0, wb_rd}, 32'd0);
        checkOutput("arst_data", wb_data, 32'd0);
        checkOutput("arst_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        arst_n = 1'b1;
        checkOutput("ready_after_rst", {31'd0, in_ready}, 32'd1);
        idleCycles(1, 1'b1);
        idleCycles(3, 1'b0);
        checkOutput("ready_end", {31'd0, in_ready}, 32'd1);
        checkOutput("drain", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
